// File: rtl/allophone_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : allophone_queue_if
// Description : Writer/generator side signals of the allophone queue.
// Revision    : 1.0  initial release
// ============================================================================
interface allophone_queue_if;
    logic [5:0] data;
    logic       write;
    logic       busy;
    logic [5:0] code;
    logic       start;
    logic       done;
    logic       idle;

    // master = allophone writer plus sound generator; slave = the queue
    modport master (output data, write, done, input busy, code, start, idle);
    modport slave  (input data, write, done, output busy, code, start, idle);
endinterface
`default_nettype wire

// File: rtl/allophone_queue.sv
`default_nettype none
// ============================================================================
// Module      : allophone_queue
// Description : Allophone FIFO that expands pause codes into timed silence
//               and hands playable codes to the sound generator.
// Revision    : 1.0  initial release
// ============================================================================
module allophone_queue #(
    parameter int DEPTH      = 8,
    parameter int PAUSE_UNIT = 1000000,
    parameter int TIMER_W    = 25
) (
    input  wire logic        clk,
    input  wire logic        rst,
    allophone_queue_if.slave bus
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [TIMER_W-1:0] c_LOAD_U1  = TIMER_W'(PAUSE_UNIT * 1  - 1);
    localparam logic [TIMER_W-1:0] c_LOAD_U3  = TIMER_W'(PAUSE_UNIT * 3  - 1);
    localparam logic [TIMER_W-1:0] c_LOAD_U5  = TIMER_W'(PAUSE_UNIT * 5  - 1);
    localparam logic [TIMER_W-1:0] c_LOAD_U10 = TIMER_W'(PAUSE_UNIT * 10 - 1);
    localparam logic [TIMER_W-1:0] c_LOAD_U20 = TIMER_W'(PAUSE_UNIT * 20 - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_PLAY   = 2'd2,
        S_PAUSE  = 2'd3
    } state_t;

    logic [5:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    state_t             r_state;
    state_t             w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic [5:0]         r_code;
    logic [5:0]         w_code_next;
    logic               r_start;
    logic               w_start_next;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_pop;
    logic [TIMER_W-1:0] w_pause_load;

    // busy comes only from the registered count, never from write
    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.write & ~w_full;

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem[r_wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Pause codes 0..4 map to 1, 3, 5, 10, 20 units of silence
    always_comb begin
        case (r_code[2:0])
            3'd0:    w_pause_load = c_LOAD_U1;
            3'd1:    w_pause_load = c_LOAD_U3;
            3'd2:    w_pause_load = c_LOAD_U5;
            3'd3:    w_pause_load = c_LOAD_U10;
            default: w_pause_load = c_LOAD_U20;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_code  <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_code  <= w_code_next;
            r_start <= w_start_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_code_next  = r_code;
        w_start_next = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_code_next  = r_mem[r_rd_ptr];
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_code <= 6'd4) begin
                    w_timer_next = w_pause_load;
                    w_state_next = S_PAUSE;
                end else begin
                    w_start_next = 1'b1;
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                // r_start marks the first PLAY cycle, where done is ignored
                if (!r_start && bus.done) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PAUSE: begin
                if (r_timer == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer - TIMER_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.busy  = w_full;
    assign bus.code  = r_code;
    assign bus.start = r_start;
    assign bus.idle  = (r_state == S_IDLE) & w_empty;

endmodule
`default_nettype wire
